adc128s022_responder: RTL and testbench

Synthesizable responder for the ADC128S022 serial interface. It emulates the ADC side of the link: it samples CS_N, SCLK and SADDR driven by an ADC master, and shifts 12-bit channel samples out on SDAT. It serves as a loopback target for the ADC reader on a second board or in simulation. Channel sample values are loaded from fabric through a simple write port.

---
 rtl/adc128s022_responder_if.sv | 10 +
 rtl/adc128s022_responder.sv | 140 ++++++++++++++
 tb/tb_adc128s022_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc128s022_responder_if.sv
// Serial link between an ADC128S022 master and the responder.
interface adc128s022_responder_if;
   logic CS_N;
   logic SCLK;
   logic SADDR;
   logic SDAT;

   modport master (output CS_N, output SCLK, output SADDR, input SDAT);
   modport slave  (input CS_N, input SCLK, input SADDR, output SDAT);
endinterface

// File: rtl/adc128s022_responder.sv
// ADC128S022 responder: emulates the ADC side of the serial link.
// Returns 12-bit samples from a fabric-written register file and captures the
// channel address for the following frame.
module adc128s022_responder #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   adc128s022_responder_if.slave  adc,
   input  logic                   ch_wr_en,
   input  logic [2:0]             ch_wr_addr,
   input  logic [11:0]            ch_wr_data,
   output logic [2:0]             cur_channel,
   output logic                   frame_done,
   output logic [15:0]            frame_count
);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, FRAME} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, saddr_sync;
   logic cs_d, sclk_d;
   logic cs, sclk, saddr;
   logic cs_fall, cs_rise, sclk_fall, sclk_rise;
   logic start_frame, in_frame;

   logic [11:0] sample [8];
   logic [11:0] load_value;
   logic [15:0] shift;
   logic [4:0]  rise_cnt;
   logic [2:0]  addr_cap;
   logic        sdat_q;

   assign cs    = cs_sync[SYNC_STAGES-1];
   assign sclk  = sclk_sync[SYNC_STAGES-1];
   assign saddr = saddr_sync[SYNC_STAGES-1];

   assign cs_fall   = cs_d & ~cs;
   assign cs_rise   = ~cs_d & cs;
   assign sclk_fall = sclk_d & ~sclk;
   assign sclk_rise = ~sclk_d & sclk;

   // Synchronize the asynchronous master pins and register them for edge detection.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cs_sync    <= '0;
         sclk_sync  <= '0;
         saddr_sync <= '0;
         cs_d       <= 1'b0;
         sclk_d     <= 1'b0;
      end else begin
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], adc.CS_N};
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], adc.SCLK};
         saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], adc.SADDR};
         cs_d       <= cs;
         sclk_d     <= sclk;
      end
   end

   // Sample register file written from fabric.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 8; i++) sample[i] <= '0;
      end else if (ch_wr_en) begin
         sample[ch_wr_addr] <= ch_wr_data;
      end
   end

   // A write to the converted channel in the frame-start cycle is forwarded.
   assign load_value = (ch_wr_en && (ch_wr_addr == cur_channel)) ? ch_wr_data
                                                                  : sample[cur_channel];

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) state <= WAIT_IDLE;
      else          state <= state_next;
   end

   // Next-state logic; a CS_N rise in FRAME masks any coincident SCLK edge.
   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      in_frame    = 1'b0;
      case (state)
         WAIT_IDLE: if (cs) state_next = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_next  = FRAME;
               start_frame = 1'b1;
            end
         end
         FRAME: begin
            if (cs_rise) state_next = IDLE;
            else         in_frame   = 1'b1;
         end
         default: state_next = WAIT_IDLE;
      endcase
   end

   // Shift-out, address capture and frame completion bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shift       <= '0;
         rise_cnt    <= '0;
         addr_cap    <= '0;
         cur_channel <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         sdat_q      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sdat_q     <= (state == FRAME) & shift[15];
         if (start_frame) begin
            shift    <= {4'b0000, load_value};
            rise_cnt <= '0;
            addr_cap <= '0;
         end else if (in_frame) begin
            if (sclk_fall) shift <= {shift[14:0], 1'b0};
            if (sclk_rise && (rise_cnt < 5'd16)) begin
               rise_cnt <= rise_cnt + 5'd1;
               case (rise_cnt)
                  5'd2:  addr_cap[2] <= saddr;
                  5'd3:  addr_cap[1] <= saddr;
                  5'd4:  addr_cap[0] <= saddr;
                  5'd15: begin
                     cur_channel <= addr_cap;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign adc.SDAT = sdat_q;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Self-checking bench for adc128s022_responder: acts as the ADC master,
// checks returned words against a scoreboard and checks frame status outputs.
module tb_adc128s022_responder;

   logic        clock;
   logic        reset_n;
   logic        ch_wr_en;
   logic [2:0]  ch_wr_addr;
   logic [11:0] ch_wr_data;
   logic [2:0]  cur_channel;
   logic        frame_done;
   logic [15:0] frame_count;

   adc128s022_responder_if bus ();

   adc128s022_responder #(.SYNC_STAGES(2)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .adc         (bus.slave),
      .ch_wr_en    (ch_wr_en),
      .ch_wr_addr  (ch_wr_addr),
      .ch_wr_data  (ch_wr_data),
      .cur_channel (cur_channel),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   // Model state
   logic [11:0] m_sample [8];
   logic [2:0]  m_cur;
   logic [15:0] m_count;
   logic [15:0] exp_q [$];

   always @(negedge clock) if (frame_done === 1'b1) done_cnt++;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] val);
      ch_wr_en = 1'b1; ch_wr_addr = ch; ch_wr_data = val;
      tick(1);
      ch_wr_en = 1'b0;
      m_sample[ch] = val;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_sample[i] = '0;
      m_cur = '0;
      m_count = '0;
   endtask

   // Master frame: SCLK idles high, SADDR driven after each fall, SDAT sampled just before each rise.
   task automatic run_frame(input logic [2:0] addr, input int ncyc, input logic start_wr,
                            input logic [11:0] start_data, output logic [15:0] word);
      word = '0;
      bus.CS_N = 1'b0;
      if (start_wr) begin
         tick(2);
         ch_wr_en = 1'b1; ch_wr_addr = m_cur; ch_wr_data = start_data;
         tick(1);
         ch_wr_en = 1'b0;
         m_sample[m_cur] = start_data;
         tick(5);
      end else begin
         tick(8);
      end
      for (int k = 1; k <= ncyc; k++) begin
         bus.SCLK = 1'b0;
         bus.SADDR = (k >= 3 && k <= 5) ? addr[5-k] : 1'b0;
         tick(8);
         if (k <= 16) word[16-k] = bus.SDAT;
         bus.SCLK = 1'b1;
         tick(8);
      end
      bus.CS_N = 1'b1;
      tick(10);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; bus.CS_N = 1'b1; bus.SCLK = 1'b1; bus.SADDR = 1'b0;
      ch_wr_en = 1'b0; ch_wr_addr = '0; ch_wr_data = '0;
      model_reset();
      tick(5);
      reset_n = 1'b1;
      tick(1);
      n_cmp++; if (bus.SDAT !== 1'b0) begin n_bad++; $display("FAIL reset_sdat got %b exp 0", bus.SDAT); end
      n_cmp++; if (cur_channel !== 3'd0) begin n_bad++; $display("FAIL reset_cur got %0d exp 0", cur_channel); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", frame_done); end
      n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", frame_count); end
      tick(6);
   endtask

   task automatic test_first_frame();
      logic [15:0] w, e;
      int d0;
      wr(3'd0, 12'hA5C);
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      d0 = done_cnt;
      run_frame(3'd3, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_cur = 3'd3; m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL first_word got %h exp %h", w, e); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL first_done got %0d pulses exp 1", done_cnt - d0); end
      n_cmp++; if (cur_channel !== m_cur) begin n_bad++; $display("FAIL first_cur got %0d exp %0d", cur_channel, m_cur); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL first_count got %0d exp %0d", frame_count, m_count); end
   endtask

   task automatic test_pipelined();
      logic [15:0] w, e;
      logic [2:0] addrs [2];
      addrs[0] = 3'd6; addrs[1] = 3'd0;
      wr(3'd3, 12'h123);
      wr(3'd6, 12'hFFF);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
         run_frame(addrs[i], 16, 1'b0, '0, w);
         e = exp_q.pop_front(); m_cur = addrs[i]; m_count++;
         n_cmp++; if (w !== e) begin n_bad++; $display("FAIL pipe_word%0d got %h exp %h", i, w, e); end
      end
      n_cmp++; if (cur_channel !== m_cur) begin n_bad++; $display("FAIL pipe_cur got %0d exp %0d", cur_channel, m_cur); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL pipe_count got %0d exp %0d", frame_count, m_count); end
   endtask

   task automatic test_abort();
      logic [15:0] w, e;
      int d0;
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      run_frame(3'd3, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_cur = 3'd3; m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL abort_setup_word got %h exp %h", w, e); end
      d0 = done_cnt;
      run_frame(3'd5, 8, 1'b0, '0, w);
      n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL abort_done got %0d pulses exp 0", done_cnt - d0); end
      n_cmp++; if (cur_channel !== m_cur) begin n_bad++; $display("FAIL abort_cur got %0d exp %0d", cur_channel, m_cur); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL abort_count got %0d exp %0d", frame_count, m_count); end
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      run_frame(3'd3, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL abort_next_word got %h exp %h", w, e); end
   endtask

   task automatic test_write_during_frame();
      logic [15:0] w, e;
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      fork
         run_frame(3'd3, 16, 1'b0, '0, w);
         begin tick(100); wr(3'd3, 12'h777); end
      join
      e = exp_q.pop_front(); m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL wdf_old_word got %h exp %h", w, e); end
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      run_frame(3'd3, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL wdf_new_word got %h exp %h", w, e); end
      run_frame(3'd3, 16, 1'b1, 12'hABC, w);
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      e = exp_q.pop_front(); m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL wdf_same_cycle_word got %h exp %h", w, e); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL wdf_count got %0d exp %0d", frame_count, m_count); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] w, e;
      int d0, ones;
      bus.CS_N = 1'b0;
      tick(8);
      for (int k = 0; k < 4; k++) begin
         bus.SCLK = 1'b0; tick(8); bus.SCLK = 1'b1; tick(8);
      end
      reset_n = 1'b0;
      tick(4);
      reset_n = 1'b1;
      model_reset();
      d0 = done_cnt; ones = 0;
      for (int k = 0; k < 16; k++) begin
         bus.SCLK = 1'b0; bus.SADDR = 1'b1; tick(8);
         if (bus.SDAT !== 1'b0) ones++;
         bus.SCLK = 1'b1; tick(8);
      end
      bus.CS_N = 1'b1; bus.SADDR = 1'b0;
      tick(10);
      n_cmp++; if (ones !== 0) begin n_bad++; $display("FAIL rmf_sdat got %0d nonzero bits exp 0", ones); end
      n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL rmf_done got %0d pulses exp 0", done_cnt - d0); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL rmf_count got %0d exp %0d", frame_count, m_count); end
      wr(3'd0, 12'h5A5);
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      run_frame(3'd2, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_cur = 3'd2; m_count++;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL rmf_resume_word got %h exp %h", w, e); end
      n_cmp++; if (cur_channel !== m_cur) begin n_bad++; $display("FAIL rmf_resume_cur got %0d exp %0d", cur_channel, m_cur); end
   endtask

   task automatic test_counter_wrap();
      logic [15:0] w, e;
      int d0;
      force dut.frame_count = 16'hFFFF;
      tick(1);
      release dut.frame_count;
      tick(1);
      m_count = 16'hFFFF;
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL wrap_preload got %h exp %h", frame_count, m_count); end
      d0 = done_cnt;
      exp_q.push_back({3'b000, m_sample[m_cur], 1'b0});
      run_frame(3'd1, 16, 1'b0, '0, w);
      e = exp_q.pop_front(); m_cur = 3'd1; m_count = m_count + 16'd1;
      n_cmp++; if (w !== e) begin n_bad++; $display("FAIL wrap_word got %h exp %h", w, e); end
      n_cmp++; if (frame_count !== m_count) begin n_bad++; $display("FAIL wrap_count got %h exp %h", frame_count, m_count); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL wrap_done got %0d pulses exp 1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_pipelined();
      test_abort();
      test_write_during_frame();
      test_reset_mid_frame();
      test_counter_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog timeout after %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
